// File: rtl/program_loader.sv
// Byte-stream loader for the 16x8 instruction SRAM.
// Holds the CPU in reset until a checksum-clean image is written.
module program_loader #(
  parameter int ADDR   = 4,
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sram_cs,
  output logic             sram_we,
  output logic [ADDR-1:0]  sram_addr,
  output logic [WIDTH-1:0] sram_data,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ADDR:0]    count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam logic [ADDR-1:0] LAST = ADDR'(LENGTH - 1);
  localparam logic [ADDR:0]   ONE  = (ADDR+1)'(1);

  logic [2:0]       state_q, state_d;
  logic [ADDR-1:0]  idx_q, idx_d;
  logic [ADDR:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             wr_q, wr_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             beat;
  logic [WIDTH-1:0] sum_next;

  assign in_ready = (state_q == LOAD) || (state_q == CHECK);
  assign busy     = in_ready;
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERROR);
  assign cpu_reset = (state_q != DONE);
  assign count    = cnt_q;
  assign sram_cs  = wr_q;
  assign sram_we  = wr_q;
  assign sram_addr = addr_q;
  assign sram_data = data_q;

  assign beat     = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      LOAD: begin
        if (beat) begin
          wr_d   = 1'b1;
          addr_d = idx_q;
          data_d = in_data;
          sum_d  = sum_next;
          cnt_d  = cnt_q + ONE;
          // index parks on the last word instead of wrapping
          if (idx_q == LAST) state_d = CHECK;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      CHECK: begin
        if (beat) begin
          if (sum_next == '0) state_d = DONE;
          else                state_d = ERROR;
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: clean, bad-checksum, stalled,
// reset-interrupted and reloaded images.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       sram_cs;
  logic       sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] count;

  program_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int wr_bad = 0;
  logic exp_wr = 1'b0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write port watcher: a write must follow exactly each accepted data beat.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_wr = 1'b0;
    end else begin
      if ((sram_cs && sram_we) !== exp_wr || sram_cs !== sram_we) wr_bad++;
      if (sram_cs && sram_we) begin
        wa.push_back(sram_addr);
        wd.push_back(sram_data);
      end
      exp_wr = in_valid && in_ready && (count < 5'd16);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic chk_writes(input string tag, input logic [7:0] img[16]);
    chk({tag, "_nwr"}, wa.size(), 16);
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], i);
      chk({tag, "_data"}, wd[i], img[i]);
    end
    chk({tag, "_timing"}, wr_bad, 0);
  endtask

  logic [7:0] ramp[16];
  logic [7:0] a5s[16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i] = 8'(i);
      a5s[i]  = 8'hA5;
    end
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data", sram_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (3) begin
      chk("idle_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("idle_nwr", wa.size(), 0);
    chk("idle_busy", busy, 0);

    // clean load
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_count", count, 0);
    for (int i = 0; i < 16; i++) send(ramp[i], 0);
    chk("clean_count", count, 16);
    chk("clean_in_check", busy, 1);
    chk("clean_cpu_held", cpu_reset, 1);
    send(8'h88, 0);
    chk("clean_done", done, 1);
    chk("clean_error", error, 0);
    chk("clean_cpu_reset", cpu_reset, 0);
    chk("clean_busy", busy, 0);
    chk("clean_in_ready", in_ready, 0);
    tick();
    chk_writes("clean", ramp);

    // reload from DONE with a different image
    wa.delete();
    wd.delete();
    pulse_start();
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_done", done, 0);
    chk("reload_count", count, 0);
    for (int i = 0; i < 16; i++) send(a5s[i], 0);
    send(8'hB0, 0);
    chk("reload_done2", done, 1);
    chk("reload_cpu_run", cpu_reset, 0);
    tick();
    chk_writes("reload", a5s);

    // bad checksum
    wa.delete();
    wd.delete();
    pulse_start();
    for (int i = 0; i < 16; i++) send(ramp[i], 0);
    send(8'h87, 0);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_reset", cpu_reset, 1);
    tick();
    chk_writes("bad", ramp);

    // stalled load with an ignored start at count=5
    wa.delete();
    wd.delete();
    pulse_start();
    chk("stall_error_clr", error, 0);
    chk("stall_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        chk("stall_pre_start", count, 5);
        pulse_start();
        chk("stall_post_start", count, 5);
        chk("stall_nwr5", wa.size(), 5);
      end
      send(ramp[i], 2);
    end
    chk("stall_count", count, 16);
    send(8'h88, 2);
    chk("stall_done", done, 1);
    chk("stall_error", error, 0);
    chk("stall_cpu_reset", cpu_reset, 0);
    chk_writes("stall", ramp);

    // reset in the middle of a load
    wa.delete();
    wd.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send(ramp[i], 0);
    chk("mid_we_before", sram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_we", sram_we, 0);
    chk("mid_count", count, 0);
    chk("mid_cpu_reset", cpu_reset, 1);
    chk("mid_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_idle_cpu", cpu_reset, 1);
    wa.delete();
    wd.delete();
    pulse_start();
    for (int i = 0; i < 16; i++) send(a5s[i], 0);
    send(8'hB0, 0);
    chk("after_rst_done", done, 1);
    chk("after_rst_cpu", cpu_reset, 0);
    tick();
    chk_writes("after_rst", a5s);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
